// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM states, parity codes, defaults.
// Also provides the 3-sample majority helper used by the sampler.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DEF_PRESCALE   = 8;
  localparam int DEF_DATA_WIDTH = 8;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rx_sampler: captures the line at three mid-bit edges and votes.
// Ports: clk_i, rst_i, rx_i, edge_cnt_i in; bit_o (majority) out.
module rx_sampler
  import uart_pkg::*;
#(
  parameter int Prescale = DEF_PRESCALE,
  parameter int EW       = $clog2(Prescale)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rx_i,
  input  logic [EW-1:0] edge_cnt_i,
  output logic          bit_o
);

  localparam int MID = Prescale / 2;

  localparam logic [EW-1:0] E0 = EW'(MID - 1);
  localparam logic [EW-1:0] E1 = EW'(MID);
  localparam logic [EW-1:0] E2 = EW'(MID + 1);

  logic [2:0] smp_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      smp_q <= '0;
    end else begin
      if (edge_cnt_i == E0) smp_q[0] <= rx_i;
      if (edge_cnt_i == E1) smp_q[1] <= rx_i;
      if (edge_cnt_i == E2) smp_q[2] <= rx_i;
    end
  end

  // All three samples are settled well before the bit's last edge.
  assign bit_o = majority3(smp_q);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing, registered result pulses.
// Ports: CLK_UART, RST_UART, RX_IN_UART, PAR_EN/TYPE in; P_DATA, pulses out.
module uart_rx
  import uart_pkg::*;
#(
  parameter int Data_Width = DEF_DATA_WIDTH,
  parameter int Prescale   = DEF_PRESCALE
) (
  input  logic                  CLK_UART,
  input  logic                  RST_UART,
  input  logic                  RX_IN_UART,
  input  logic                  PAR_EN_UART,
  input  logic                  PAR_TYPE_UART,
  output logic [Data_Width-1:0] P_DATA_UART,
  output logic                  DATA_VALID_UART,
  output logic                  PAR_ERR_UART,
  output logic                  STP_ERR_UART
);

  localparam int EW = $clog2(Prescale);
  localparam int BW = (Data_Width > 1) ? $clog2(Data_Width) : 1;

  localparam logic [EW-1:0] EDGE_LAST = EW'(Prescale - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(Data_Width - 1);

  rx_state_e             state_q;
  logic [EW-1:0]         edge_cnt_q;
  logic [EW-1:0]         edge_cnt_d;
  logic [BW-1:0]         bit_cnt_q;
  logic [Data_Width-1:0] shreg_q;
  logic                  par_en_q;
  logic                  par_type_q;
  logic                  par_bit_q;
  logic [Data_Width-1:0] pdata_q;
  logic                  valid_q;
  logic                  perr_q;
  logic                  serr_q;

  logic smp_bit;
  logic edge_last;
  logic par_exp;
  logic frame_perr;
  logic frame_serr;

  rx_sampler #(
    .Prescale (Prescale),
    .EW       (EW)
  ) u_sampler (
    .clk_i      (CLK_UART),
    .rst_i      (RST_UART),
    .rx_i       (RX_IN_UART),
    .edge_cnt_i (edge_cnt_q),
    .bit_o      (smp_bit)
  );

  assign edge_last  = (edge_cnt_q == EDGE_LAST);
  assign edge_cnt_d = edge_last ? '0 : edge_cnt_q + 1'b1;

  assign par_exp    = (^shreg_q) ^ (par_type_q == PAR_ODD);
  assign frame_perr = par_en_q & (par_bit_q ^ par_exp);
  // smp_bit holds the stop-bit vote while in STOP.
  assign frame_serr = ~smp_bit;

  always_ff @(posedge CLK_UART) begin
    if (RST_UART) begin
      state_q    <= S_IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      par_bit_q  <= 1'b0;
      pdata_q    <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      serr_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          edge_cnt_q <= '0;
          bit_cnt_q  <= '0;
          // The falling-edge cycle is edge 0 of the start bit.
          if (!RX_IN_UART) begin
            state_q    <= S_START;
            edge_cnt_q <= EW'(1);
          end
        end
        S_START: begin
          edge_cnt_q <= edge_cnt_d;
          if (edge_last) begin
            if (!smp_bit) begin
              state_q    <= S_DATA;
              par_en_q   <= PAR_EN_UART;
              par_type_q <= PAR_TYPE_UART;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          edge_cnt_q <= edge_cnt_d;
          if (edge_last) begin
            shreg_q[bit_cnt_q] <= smp_bit;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          edge_cnt_q <= edge_cnt_d;
          if (edge_last) begin
            par_bit_q <= smp_bit;
            state_q   <= S_STOP;
          end
        end
        S_STOP: begin
          edge_cnt_q <= edge_cnt_d;
          if (edge_last) begin
            state_q <= S_IDLE;
            perr_q  <= frame_perr;
            serr_q  <= frame_serr;
            if (!frame_perr && !frame_serr) begin
              valid_q <= 1'b1;
              pdata_q <= shreg_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign P_DATA_UART     = pdata_q;
  assign DATA_VALID_UART = valid_q;
  assign PAR_ERR_UART    = perr_q;
  assign STP_ERR_UART    = serr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames plus random traffic.
// Stimulus pushes expected outcomes; a monitor pops on each pulse.
module tb_uart_rx;

  localparam int P  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          pen = 1'b0;
  logic          ptype = 1'b0;
  logic [DW-1:0] pdata;
  logic          dv;
  logic          perr;
  logic          serr;

  always #5 clk = ~clk;

  uart_rx #(
    .Data_Width (DW),
    .Prescale   (P)
  ) dut (
    .CLK_UART        (clk),
    .RST_UART        (rst),
    .RX_IN_UART      (rx),
    .PAR_EN_UART     (pen),
    .PAR_TYPE_UART   (ptype),
    .P_DATA_UART     (pdata),
    .DATA_VALID_UART (dv),
    .PAR_ERR_UART    (perr),
    .STP_ERR_UART    (serr)
  );

  typedef struct {
    bit          v;
    bit          pe;
    bit          se;
    logic [7:0]  d;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_ok = 8'h00;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: samples 2ns after the active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!rst && (dv || perr || serr)) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got v=%0b pe=%0b se=%0b want none",
                   dv, perr, serr);
        end else begin
          e = sb.pop_front();
          chk("data_valid", 32'(dv), 32'(e.v));
          chk("stp_err", 32'(serr), 32'(e.se));
          if (!e.se) chk("par_err", 32'(perr), 32'(e.pe));
          if (e.v) last_ok = e.d;
          chk("p_data", 32'(pdata), 32'(last_ok));
        end
      end
    end
  end

  task automatic send_bit(logic b);
    rx = b;
    repeat (P) @(negedge clk);
  endtask

  task automatic idle(int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Reference: frame outcome from data, parity settings and line bits.
  task automatic send_frame(logic [7:0] d, bit en, bit typ,
                            bit par_ok, bit stop, bit jitter);
    exp_t e;
    int   ones;
    bit   pgood;
    bit   pbit;
    ones = 0;
    for (int i = 0; i < DW; i++) ones += int'(d[i]);
    pgood = bit'(ones % 2) ^ typ;
    pbit  = par_ok ? pgood : ~pgood;
    e.se  = !stop;
    e.pe  = en && !par_ok;
    e.v   = stop && !e.pe;
    e.d   = d;
    sb.push_back(e);
    pen   = en;
    ptype = typ;
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) begin
      if (jitter) begin
        pen   = 1'($urandom);
        ptype = 1'($urandom);
      end
      send_bit(d[i]);
    end
    if (en) send_bit(pbit);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    bit         en;
    bit         typ;
    bit         pok;
    bit         stp;
    int         gap;

    repeat (3) @(negedge clk);
    chk("rst_p_data", 32'(pdata), 32'd0);
    chk("rst_valid", 32'(dv), 32'd0);
    chk("rst_perr", 32'(perr), 32'd0);
    chk("rst_serr", 32'(serr), 32'd0);
    rst = 1'b0;
    idle(4);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(4);
    drain("drain_a5_even");
    chk("p_data_a5", 32'(pdata), 32'hA5);

    // 0xA5 has four ones, so parity bit 0 is wrong for odd parity.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(4);
    drain("drain_a5_odd");
    chk("p_data_hold_perr", 32'(pdata), 32'hA5);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(4);
    drain("drain_3c_stop0");
    chk("p_data_hold_serr", 32'(pdata), 32'hA5);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(4);
    drain("drain_3c_stop1");
    chk("p_data_3c", 32'(pdata), 32'h3C);

    // Start glitch: two low cycles then high; nothing expected.
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(3 * P);
    chk("glitch_no_pulse", 32'(sb.size()), 32'd0);
    chk("p_data_glitch", 32'(pdata), 32'h3C);

    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(4);
    drain("drain_b2b");
    chk("p_data_b2b", 32'(pdata), 32'hFF);

    // Reset in the middle of data bit 4.
    d = 8'h96;
    pen = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    chk("mid_rst_p_data", 32'(pdata), 32'd0);
    chk("mid_rst_valid", 32'(dv), 32'd0);
    chk("mid_rst_perr", 32'(perr), 32'd0);
    chk("mid_rst_serr", 32'(serr), 32'd0);
    rst = 1'b0;
    last_ok = 8'h00;
    idle(3 * P);
    chk("mid_rst_no_pulse", 32'(sb.size()), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);
    drain("drain_after_rst");
    chk("p_data_after_rst", 32'(pdata), 32'h5A);

    for (int n = 0; n < 40; n++) begin
      d   = 8'($urandom);
      en  = 1'($urandom);
      typ = 1'($urandom);
      pok = ($urandom_range(0, 9) < 8);
      stp = ($urandom_range(0, 9) < 8);
      gap = $urandom_range(0, 3);
      send_frame(d, en, typ, pok, stp, 1'b1);
      if (gap != 0) idle(gap);
    end
    idle(4);
    drain("drain_random");
    chk("p_data_final", 32'(pdata), 32'(last_ok));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
